fetch_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register for the 16-bit WISC core.

---
 rtl/wisc_pkg.sv | 19 +
 rtl/fetch_stage_if.sv | 33 +++
 rtl/pc_reg.sv | 25 ++
 rtl/fetch_stage.sv | 107 ++++++++++
 tb/tb_fetch_stage.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/wisc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wisc_pkg : opcodes, bubble word and front-end state encoding shared  |
// |            by the 16-bit WISC pipeline.                              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package wisc_pkg;
  localparam logic [3:0]  OP_HLT    = 4'hF;
  localparam logic [3:0]  OP_B      = 4'hC;
  localparam logic [3:0]  OP_BR     = 4'hD;
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    FS_RUN    = 2'd0,
    FS_DRAIN  = 2'd1,
    FS_HALTED = 2'd2
  } fetch_state_e;
endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_stage_if : instruction-memory, hazard/redirect and IF/ID       |
// |                  signals around the fetch stage.                     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface fetch_stage_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              stall;
  logic              redirect;
  logic [DATA_W-1:0] redirect_pc;
  logic              hlt_commit;
  logic [DATA_W-1:0] id_instr;
  logic [3:0]        id_op;
  logic [DATA_W-1:0] id_pc_plus;
  logic              id_valid;
  logic              halted;

  // master = the fetch stage itself
  modport master (
    output imem_addr, id_instr, id_op, id_pc_plus, id_valid, halted,
    input  imem_data, stall, redirect, redirect_pc, hlt_commit
  );

  modport slave (
    input  imem_addr, id_instr, id_op, id_pc_plus, id_valid, halted,
    output imem_data, stall, redirect, redirect_pc, hlt_commit
  );
endinterface
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_reg : program-counter register with load enable and async reset.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pc_reg #(
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_en,
  input  wire logic [DATA_W-1:0] i_d,
  output logic      [DATA_W-1:0] o_q
);
  logic [DATA_W-1:0] r_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_pc <= RESET_PC;
    else if (i_en) r_pc <= i_d;
  end

  assign o_q = r_pc;
endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_stage : PC, next-PC mux, front-end FSM and IF/ID register for  |
// |               the WISC core; drains and halts on HLT.                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_stage #(
  parameter int                DATA_W   = 16,
  parameter int                PC_INC   = 2,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  wire logic    clk,
  input  wire logic    rst,
  fetch_stage_if.master bus
);
  import wisc_pkg::*;

  localparam logic [DATA_W-1:0] c_pc_inc = DATA_W'(PC_INC);
  localparam logic [DATA_W-1:0] c_bubble = DATA_W'(NOP_INSTR);

  fetch_state_e      r_state, w_state_nxt;
  logic [DATA_W-1:0] w_pc, w_pc_plus, w_pc_d;
  logic              w_pc_en;
  logic              w_if_load;
  logic [DATA_W-1:0] r_id_instr, r_id_pc_plus, w_id_instr_d, w_id_pc_plus_d;
  logic              r_id_valid, w_id_valid_d;

  pc_reg #(
    .DATA_W   (DATA_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_pc_en),
    .i_d  (w_pc_d),
    .o_q  (w_pc)
  );

  assign w_pc_plus = w_pc + c_pc_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FS_RUN;
    else     r_state <= w_state_nxt;
  end

  // Priority on every edge: HALTED > redirect > stall > normal.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_en        = 1'b0;
    w_pc_d         = w_pc_plus;
    w_if_load      = 1'b0;
    w_id_instr_d   = c_bubble;
    w_id_pc_plus_d = '0;
    w_id_valid_d   = 1'b0;
    case (r_state)
      FS_RUN: begin
        if (bus.redirect) begin
          w_pc_en   = 1'b1;
          w_pc_d    = bus.redirect_pc;
          w_if_load = 1'b1;
        end else if (!bus.stall) begin
          w_pc_en        = 1'b1;
          w_if_load      = 1'b1;
          w_id_instr_d   = bus.imem_data;
          w_id_pc_plus_d = w_pc_plus;
          w_id_valid_d   = 1'b1;
          if (bus.imem_data[DATA_W-1 -: 4] == OP_HLT) w_state_nxt = FS_DRAIN;
        end
      end
      FS_DRAIN: begin
        // A redirect here comes from an older branch, so the HLT was wrong-path.
        if (bus.redirect) begin
          w_pc_en     = 1'b1;
          w_pc_d      = bus.redirect_pc;
          w_if_load   = 1'b1;
          w_state_nxt = FS_RUN;
        end else if (bus.hlt_commit) begin
          w_if_load   = 1'b1;
          w_state_nxt = FS_HALTED;
        end else if (!bus.stall) begin
          w_if_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_instr   <= c_bubble;
      r_id_pc_plus <= '0;
      r_id_valid   <= 1'b0;
    end else if (w_if_load) begin
      r_id_instr   <= w_id_instr_d;
      r_id_pc_plus <= w_id_pc_plus_d;
      r_id_valid   <= w_id_valid_d;
    end
  end

  assign bus.imem_addr  = w_pc;
  assign bus.id_instr   = r_id_instr;
  assign bus.id_op      = r_id_instr[DATA_W-1 -: 4];
  assign bus.id_pc_plus = r_id_pc_plus;
  assign bus.id_valid   = r_id_valid;
  assign bus.halted     = (r_state == FS_HALTED);
endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_stage : directed self-checking bench for fetch_stage.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fetch_stage;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  logic [15:0] mem [0:32767];

  fetch_stage_if #(.DATA_W(16)) bus ();

  fetch_stage #(
    .DATA_W   (16),
    .PC_INC   (2),
    .RESET_PC (16'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.imem_data = mem[bus.imem_addr[15:1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_id(input string tag, input logic [15:0] instr, input logic [15:0] pcp,
                        input logic valid, input logic [15:0] addr);
    check({tag, ".instr"}, 32'(bus.id_instr), 32'(instr));
    check({tag, ".op"},    32'(bus.id_op), 32'(instr[15:12]));
    check({tag, ".pcp"},   32'(bus.id_pc_plus), 32'(pcp));
    check({tag, ".valid"}, 32'(bus.id_valid), 32'(valid));
    check({tag, ".addr"},  32'(bus.imem_addr), 32'(addr));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
    mem[16'h0000 >> 1] = 16'h1123;
    mem[16'h0002 >> 1] = 16'h2456;
    mem[16'h0004 >> 1] = 16'h3789;
    mem[16'h0006 >> 1] = 16'h7000;
    mem[16'h0008 >> 1] = 16'hF000;
    mem[16'h0010 >> 1] = 16'hF123;
    mem[16'h0040 >> 1] = 16'h4ABC;
    mem[16'h0100 >> 1] = 16'h5A5A;
    mem[16'hFFFE >> 1] = 16'h6111;

    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.hlt_commit = 1'b0;
    repeat (2) step();
    chk_id("reset", 16'h0000, 16'h0000, 1'b0, 16'h0000);
    check("reset.halted", 32'(bus.halted), 32'd0);
    rst = 1'b0;

    // sequential fetch
    step();
    chk_id("seq1", 16'h1123, 16'h0002, 1'b1, 16'h0002);
    step();
    chk_id("seq2", 16'h2456, 16'h0004, 1'b1, 16'h0004);

    // two-cycle stall, then resume without loss or duplication
    bus.stall = 1'b1;
    step();
    chk_id("stall1", 16'h2456, 16'h0004, 1'b1, 16'h0004);
    step();
    chk_id("stall2", 16'h2456, 16'h0004, 1'b1, 16'h0004);
    bus.stall = 1'b0;
    step();
    chk_id("resume", 16'h3789, 16'h0006, 1'b1, 16'h0006);

    // hlt_commit in RUN is ignored
    bus.hlt_commit = 1'b1;
    step();
    bus.hlt_commit = 1'b0;
    chk_id("hltrun", 16'h7000, 16'h0008, 1'b1, 16'h0008);
    check("hltrun.halted", 32'(bus.halted), 32'd0);

    // redirect beats stall
    bus.stall = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'h0040;
    step();
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    chk_id("redir", 16'h0000, 16'h0000, 1'b0, 16'h0040);
    step();
    chk_id("after_redir", 16'h4ABC, 16'h0042, 1'b1, 16'h0042);

    // HLT at 0x0008
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'h0008;
    step();
    bus.redirect = 1'b0;
    chk_id("to8", 16'h0000, 16'h0000, 1'b0, 16'h0008);
    step();
    chk_id("hlt", 16'hF000, 16'h000A, 1'b1, 16'h000A);
    bus.stall = 1'b1;
    step();
    bus.stall = 1'b0;
    chk_id("drain_stall", 16'hF000, 16'h000A, 1'b1, 16'h000A);
    step();
    chk_id("drain_bub", 16'h0000, 16'h0000, 1'b0, 16'h000A);
    check("drain.halted", 32'(bus.halted), 32'd0);
    bus.hlt_commit = 1'b1;
    step();
    bus.hlt_commit = 1'b0;
    check("halt.halted", 32'(bus.halted), 32'd1);
    check("halt.valid", 32'(bus.id_valid), 32'd0);
    check("halt.addr", 32'(bus.imem_addr), 32'h000A);
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'h0200;
    bus.hlt_commit = 1'b1;
    step();
    step();
    bus.redirect = 1'b0;
    bus.hlt_commit = 1'b0;
    check("halted_redir.addr", 32'(bus.imem_addr), 32'h000A);
    check("halted_redir.halted", 32'(bus.halted), 32'd1);
    check("halted_redir.valid", 32'(bus.id_valid), 32'd0);

    // async reset out of HALTED
    #2 rst = 1'b1;
    #1;
    chk_id("rst_halt", 16'h0000, 16'h0000, 1'b0, 16'h0000);
    check("rst_halt.halted", 32'(bus.halted), 32'd0);
    rst = 1'b0;

    // HLT in DRAIN, redirect together with hlt_commit: redirect wins
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'h0010;
    step();
    bus.redirect = 1'b0;
    step();
    chk_id("hlt2", 16'hF123, 16'h0012, 1'b1, 16'h0012);
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'h0100;
    bus.hlt_commit = 1'b1;
    step();
    bus.redirect = 1'b0;
    bus.hlt_commit = 1'b0;
    chk_id("drain_redir", 16'h0000, 16'h0000, 1'b0, 16'h0100);
    check("drain_redir.halted", 32'(bus.halted), 32'd0);
    step();
    chk_id("back_run", 16'h5A5A, 16'h0102, 1'b1, 16'h0102);

    // PC wrap at 0xFFFE
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'hFFFE;
    step();
    bus.redirect = 1'b0;
    check("wrap.addr0", 32'(bus.imem_addr), 32'hFFFE);
    step();
    chk_id("wrap", 16'h6111, 16'h0000, 1'b1, 16'h0000);

    // reset asserted mid-DRAIN takes effect before the next edge
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'h0010;
    step();
    bus.redirect = 1'b0;
    step();
    chk_id("hlt3", 16'hF123, 16'h0012, 1'b1, 16'h0012);
    #2 rst = 1'b1;
    #1;
    chk_id("rst_drain", 16'h0000, 16'h0000, 1'b0, 16'h0000);
    check("rst_drain.halted", 32'(bus.halted), 32'd0);
    rst = 1'b0;
    step();
    chk_id("post_rst", 16'h1123, 16'h0002, 1'b1, 16'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
